dual_sequence_detector_fsm: RTL and testbench



---
 rtl/dual_sequence_detector_fsm.sv | 144 ++++++++++++++
 tb/tb_dual_sequence_detector_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_sequence_detector_fsm.sv
// rtl/dual_sequence_detector_fsm.sv - dual Moore sequence detector (1010 and 110011) on one serial bit
//
// Purpose:
//   Two independent Moore FSMs watch the same serial bit `a`, one bit per
//   rising clk edge. The 4-bit FSM flags 1010 and the 6-bit FSM flags 110011,
//   both with overlapping matches. Outputs decode registered state only, so
//   there is no combinational path from `a` to either detect output.
//
// Optional feature (macro SEQ_DET_MATCH_COUNT_EN):
//   Adds two saturating 8-bit match counters, one per detector.
//
// Ports:
//   clk           in   1  clock, rising edge
//   rst           in   1  asynchronous active-low reset
//   a             in   1  serial data bit
//   detected_4    out  1  high while the 4-bit FSM sits in its match state
//   detected_6    out  1  high while the 6-bit FSM sits in its match state
//   match_count_4 out  8  (SEQ_DET_MATCH_COUNT_EN only) saturating count of detected_4 cycles
//   match_count_6 out  8  (SEQ_DET_MATCH_COUNT_EN only) saturating count of detected_6 cycles

module dual_sequence_detector_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    output logic       detected_4,
    output logic       detected_6
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    output logic [7:0] match_count_4,
    output logic [7:0] match_count_6
`endif
);

    // State names record the suffix of the input seen so far that is still
    // a prefix of the pattern.
    typedef enum logic [2:0] {
        S4_IDLE = 3'd0,
        S4_1    = 3'd1,
        S4_10   = 3'd2,
        S4_101  = 3'd3,
        S4_1010 = 3'd4
    } state4_e;

    typedef enum logic [2:0] {
        S6_IDLE   = 3'd0,
        S6_1      = 3'd1,
        S6_11     = 3'd2,
        S6_110    = 3'd3,
        S6_1100   = 3'd4,
        S6_11001  = 3'd5,
        S6_110011 = 3'd6
    } state6_e;

    state4_e state4_q, state4_d;
    state6_e state6_q, state6_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state4_q <= S4_IDLE;
            state6_q <= S6_IDLE;
        end else begin
            state4_q <= state4_d;
            state6_q <= state6_d;
        end
    end

    // ------------------------------------------------------------------
    // 4-bit detector next state (pattern 1010)
    // ------------------------------------------------------------------
    always_comb begin
        state4_d = S4_IDLE;
        case (state4_q)
            S4_IDLE: state4_d = a ? S4_1   : S4_IDLE;
            S4_1:    state4_d = a ? S4_1   : S4_10;
            S4_10:   state4_d = a ? S4_101 : S4_IDLE;
            S4_101:  state4_d = a ? S4_1   : S4_1010;
            // After a match the trailing "10" is already a valid prefix.
            S4_1010: state4_d = a ? S4_101 : S4_IDLE;
            // Unused encodings recover to idle on the next edge.
            default: state4_d = S4_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // 6-bit detector next state (pattern 110011)
    // ------------------------------------------------------------------
    always_comb begin
        state6_d = S6_IDLE;
        case (state6_q)
            S6_IDLE:   state6_d = a ? S6_1      : S6_IDLE;
            S6_1:      state6_d = a ? S6_11     : S6_IDLE;
            S6_11:     state6_d = a ? S6_11     : S6_110;
            S6_110:    state6_d = a ? S6_1      : S6_1100;
            S6_1100:   state6_d = a ? S6_11001  : S6_IDLE;
            S6_11001:  state6_d = a ? S6_110011 : S6_IDLE;
            // The match ends in "11", which is itself a prefix; a following
            // 0 extends it to "110".
            S6_110011: state6_d = a ? S6_11     : S6_110;
            default:   state6_d = S6_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: pure decodes of registered state
    // ------------------------------------------------------------------
    assign detected_4 = (state4_q == S4_1010);
    assign detected_6 = (state6_q == S6_110011);

`ifdef SEQ_DET_MATCH_COUNT_EN
    // ------------------------------------------------------------------
    // Saturating match counters
    // ------------------------------------------------------------------
    logic [7:0] match_count_4_q, match_count_4_d;
    logic [7:0] match_count_6_q, match_count_6_d;

    always_comb begin
        match_count_4_d = match_count_4_q;
        match_count_6_d = match_count_6_q;
        if (detected_4 && (match_count_4_q != 8'hFF)) begin
            match_count_4_d = match_count_4_q + 8'd1;
        end
        if (detected_6 && (match_count_6_q != 8'hFF)) begin
            match_count_6_d = match_count_6_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count_4_q <= 8'd0;
            match_count_6_q <= 8'd0;
        end else begin
            match_count_4_q <= match_count_4_d;
            match_count_6_q <= match_count_6_d;
        end
    end

    assign match_count_4 = match_count_4_q;
    assign match_count_6 = match_count_6_q;
`endif

endmodule

// File: tb/tb_dual_sequence_detector_fsm.sv
// tb/tb_dual_sequence_detector_fsm.sv - self-checking bench for dual_sequence_detector_fsm

module tb_dual_sequence_detector_fsm;

    logic clk;
    logic rst;
    logic a;
    logic detected_4;
    logic detected_6;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [7:0] match_count_4;
    logic [7:0] match_count_6;
`endif

    dual_sequence_detector_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .detected_4   (detected_4),
        .detected_6   (detected_6)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .match_count_4(match_count_4),
        .match_count_6(match_count_6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the bits sampled since the last reset (last 6 kept)
    // and saturating match tallies.
    bit hist[$];
    int cnt4_m;
    int cnt6_m;
    logic obs4;
    logic obs6;

    function automatic bit ends_with(input bit pat[], input int len);
        if (hist.size() < len) return 1'b0;
        for (int k = 0; k < len; k++) begin
            if (hist[hist.size() - len + k] != pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit match4();
        bit p[] = '{1, 0, 1, 0};
        return ends_with(p, 4);
    endfunction

    function automatic bit match6();
        bit p[] = '{1, 1, 0, 0, 1, 1};
        return ends_with(p, 6);
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        cnt4_m = 0;
        cnt6_m = 0;
    endtask

    // One sampled bit: check outputs away from the edge, drive, clock, update model.
    task automatic step(input bit b);
        bit e4, e6;
        @(negedge clk);
        e4 = match4();
        e6 = match6();
        obs4 = detected_4;
        obs6 = detected_6;
        check("detected_4", int'(detected_4), int'(e4));
        check("detected_6", int'(detected_6), int'(e6));
`ifdef SEQ_DET_MATCH_COUNT_EN
        check("match_count_4", int'(match_count_4), cnt4_m);
        check("match_count_6", int'(match_count_6), cnt6_m);
`endif
        a = b;
        @(posedge clk);
        if (e4 && cnt4_m < 255) cnt4_m++;
        if (e6 && cnt6_m < 255) cnt6_m++;
        hist.push_back(b);
        if (hist.size() > 6) void'(hist.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = 1'($urandom);
            @(negedge clk);
            check("reset_det4", int'(detected_4), 0);
            check("reset_det6", int'(detected_6), 0);
        end
        rst = 1'b1;
        model_clear();
    endtask

    task automatic drive_str(input string s);
        for (int k = 0; k < s.len(); k++) begin
            step(s[k] == "1");
        end
    endtask

    initial begin
        bit main_bits[24] = '{0,0,1,1, 0,1,0,1, 1,0,0,1, 1,0,0,1, 1,0,1,0, 1,0,0,0};
        bit b4, b6;
        int pulses4;
        rst = 1'b0;
        a = 1'b0;
        model_clear();

        // Reset behaviour
        do_reset();

        // Main directed stream, checked against the model and the fixed pulse cycles
        for (int i = 0; i < 24; i++) begin
            step(main_bits[i]);
            b4 = (i == 7) || (i == 20) || (i == 22);
            b6 = (i == 13) || (i == 17);
            check("main_det4_cycle", int'(obs4), int'(b4));
            check("main_det6_cycle", int'(obs6), int'(b6));
        end
        step(1'b0);
`ifdef SEQ_DET_MATCH_COUNT_EN
        check("main_count4", int'(match_count_4), 3);
        check("main_count6", int'(match_count_6), 2);
`endif

        // 4-bit overlap: pulses after bits 4, 6, 8, 10
        do_reset();
        pulses4 = 0;
        drive_str("1010101010");
        for (int k = 0; k < 1; k++) begin
            step(1'b0);
        end
        check("overlap4_last_det4", int'(obs4), 1);
        check("overlap4_det6", int'(obs6), 0);

        // 6-bit overlap: 110011 then 0011
        do_reset();
        drive_str("110011");
        step(1'b0);
        check("overlap6_first", int'(obs6), 1);
        drive_str("011");
        step(1'b0);
        check("overlap6_second", int'(obs6), 1);

        // Mid-pattern asynchronous reset discards "101"
        do_reset();
        drive_str("101");
        #2 rst = 1'b0;
        #1;
        check("async_rst_det4", int'(detected_4), 0);
        check("async_rst_det6", int'(detected_6), 0);
        #1 rst = 1'b1;
        model_clear();
        step(1'b0);
        step(1'b0);
        check("midrst_no_det4", int'(obs4), 0);
        drive_str("1010");
        step(1'b0);
        check("fresh_1010_det4", int'(obs4), 1);

        // Randomized stream against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom));
        end

`ifdef SEQ_DET_MATCH_COUNT_EN
        // Saturation of the 4-bit counter
        do_reset();
        for (int r = 0; r < 300; r++) begin
            drive_str("1010");
        end
        step(1'b0);
        check("sat_count4", int'(match_count_4), 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
